key_led_flop: RTL and testbench

Single-bit registered path that captures a key level on every rising clock edge and drives it to an LED. It also flags LED edges and counts LED level changes for debug and observability. The block sits directly between a board push-button or switch input and an LED pin, as the simplest sequential element in the design.

---
 rtl/key_led_flop.sv | 74 +++++++
 tb/tb_key_led_flop.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/key_led_flop.sv
// Registered key-to-LED path with edge pulses and a level-change counter.
// Optional 2-flop input synchronizer enabled by defining KEY_LED_FLOP_SYNC_EN.
module key_led_flop #(
    parameter logic RST_VAL = 1'b0,
    parameter int   INVERT  = 0,
    parameter int   CNT_W   = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             key_in,
    output logic             led_out,
    output logic             led_rise,
    output logic             led_fall,
    output logic [CNT_W-1:0] chg_cnt
);

    localparam logic INV = (INVERT != 0);

    logic key_s;

`ifdef KEY_LED_FLOP_SYNC_EN
    // Synchronizer resets to the level that makes d equal RST_VAL.
    localparam logic SYNC_RST = RST_VAL ^ INV;

    logic [1:0] sync_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    sync_reg[gi] <= SYNC_RST;
                end else begin
                    sync_reg[gi] <= (gi == 0) ? key_in : sync_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    assign key_s = sync_reg[1];
`else
    assign key_s = key_in;
`endif

    logic             d;
    logic             change;
    logic             led_reg;
    logic             rise_reg;
    logic             fall_reg;
    logic [CNT_W-1:0] cnt_reg;

    assign d      = key_s ^ INV;
    assign change = d ^ led_reg;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            led_reg  <= RST_VAL;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
            cnt_reg  <= '0;
        end else begin
            led_reg  <= d;
            rise_reg <= d & ~led_reg;
            fall_reg <= ~d & led_reg;
            // Free-running wrap; no saturation.
            cnt_reg  <= cnt_reg + CNT_W'(change);
        end
    end

    assign led_out  = led_reg;
    assign led_rise = rise_reg;
    assign led_fall = fall_reg;
    assign chg_cnt  = cnt_reg;

endmodule

// File: tb/tb_key_led_flop.sv
// Directed bench for key_led_flop: default, inverted-key and narrow-counter instances.
module tb_key_led_flop;

`ifdef KEY_LED_FLOP_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam int N = 11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       k0 = 1'b0;
    logic       k1 = 1'b0;
    logic       k2 = 1'b0;
    logic       led0, rise0, fall0;
    logic       led1, rise1, fall1;
    logic       led2, rise2, fall2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #10 clk = ~clk;

    key_led_flop #(.RST_VAL(1'b0), .INVERT(0), .CNT_W(8)) u0 (
        .sys_clk(clk), .sys_rst_n(rst_n), .key_in(k0),
        .led_out(led0), .led_rise(rise0), .led_fall(fall0), .chg_cnt(cnt0)
    );

    key_led_flop #(.RST_VAL(1'b0), .INVERT(1), .CNT_W(8)) u1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .key_in(k1),
        .led_out(led1), .led_rise(rise1), .led_fall(fall1), .chg_cnt(cnt1)
    );

    key_led_flop #(.RST_VAL(1'b0), .INVERT(0), .CNT_W(2)) u2 (
        .sys_clk(clk), .sys_rst_n(rst_n), .key_in(k2),
        .led_out(led2), .led_rise(rise2), .led_fall(fall2), .chg_cnt(cnt2)
    );

    typedef struct {
        logic       k0;
        logic       led;
        logic       rise;
        logic       fall;
        logic [7:0] cnt;
        logic       k2;
        logic [1:0] cnt2;
    } vec_t;

    vec_t vec [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        else pass_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_led0"}, {31'd0, led0}, 32'd0);
        chk({tag, "_rise0"}, {31'd0, rise0}, 32'd0);
        chk({tag, "_fall0"}, {31'd0, fall0}, 32'd0);
        chk({tag, "_cnt0"}, {24'd0, cnt0}, 32'd0);
        chk({tag, "_led1"}, {31'd0, led1}, 32'd0);
    endtask

    logic       sh [3];
    logic       d, exp_led, exp_rise, exp_fall;
    logic [7:0] exp_cnt;

    initial begin
        //        k0    led   rise  fall  cnt  k2    cnt2
        vec[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 1'b1, 2'd1};
        vec[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 2'd2};
        vec[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd3, 1'b1, 2'd3};
        vec[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 2'd0};
        vec[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b1, 2'd1};
        vec[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 1'b1, 2'd1};
        vec[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd5, 1'b1, 2'd1};
        vec[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd6, 1'b1, 2'd1};
        vec[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd7, 1'b1, 2'd1};
        vec[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd7, 1'b1, 2'd1};
        vec[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd7, 1'b1, 2'd1};

        // Reset held across the first clock edge.
        #5;
        chk_reset_state("rst_t5");
        #10;
        chk_reset_state("rst_t15");
        #5;
        rst_n = 1'b1;

        for (int i = 0; i < N + LAT - 1; i++) begin
            int vi;
            int j;
            vi = (i < N) ? i : N - 1;
            k0 = vec[vi].k0;
            k2 = vec[vi].k2;
            tick();
            j = i - (LAT - 1);
            if (j >= 0) begin
                $display("vec %0d: k0=%0b led=%0b rise=%0b fall=%0b cnt=%0d cnt2=%0d",
                         j, vec[j].k0, led0, rise0, fall0, cnt0, cnt2);
                chk($sformatf("vec%0d_led", j), {31'd0, led0}, {31'd0, vec[j].led});
                chk($sformatf("vec%0d_rise", j), {31'd0, rise0}, {31'd0, vec[j].rise});
                chk($sformatf("vec%0d_fall", j), {31'd0, fall0}, {31'd0, vec[j].fall});
                chk($sformatf("vec%0d_cnt", j), {24'd0, cnt0}, {24'd0, vec[j].cnt});
                chk($sformatf("vec%0d_cnt2", j), {30'd0, cnt2}, {30'd0, vec[j].cnt2});
                if (j < 3) begin
                    chk($sformatf("inv%0d_led", j), {31'd0, led1}, 32'd1);
                    chk($sformatf("inv%0d_rise", j), {31'd0, rise1}, (j == 0) ? 32'd1 : 32'd0);
                    chk($sformatf("inv%0d_cnt", j), {24'd0, cnt1}, 32'd1);
                end
            end
        end

        // Random stimulus against a small reference model; pipeline is settled at 1.
        sh[0] = 1'b1; sh[1] = 1'b1; sh[2] = 1'b1;
        exp_led = 1'b1;
        exp_cnt = 8'd7;
        for (int i = 0; i < 10 + LAT; i++) begin
            k0 = (i < 10) ? 1'($urandom_range(0, 1)) : 1'b1;
            sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = k0;
            d = sh[LAT - 1];
            exp_rise = d & ~exp_led;
            exp_fall = ~d & exp_led;
            exp_cnt  = exp_cnt + {7'd0, d ^ exp_led};
            exp_led  = d;
            tick();
            $display("rnd %0d: k0=%0b led=%0b rise=%0b fall=%0b cnt=%0d", i, k0, led0, rise0, fall0, cnt0);
            chk($sformatf("rnd%0d_led", i), {31'd0, led0}, {31'd0, exp_led});
            chk($sformatf("rnd%0d_rise", i), {31'd0, rise0}, {31'd0, exp_rise});
            chk($sformatf("rnd%0d_fall", i), {31'd0, fall0}, {31'd0, exp_fall});
            chk($sformatf("rnd%0d_cnt", i), {24'd0, cnt0}, {24'd0, exp_cnt});
        end

        // Mid-clock reset must clear immediately and hold across edges.
        #4;
        rst_n = 1'b0;
        #1;
        chk_reset_state("arst_now");
        #15;
        chk_reset_state("arst_hold");
        #24;
        rst_n = 1'b1;
        $display("reset released at %0t, k0=%0b", $time, k0);

        for (int i = 0; i < LAT; i++) begin
            tick();
            if (i < LAT - 1) chk($sformatf("post_rst%0d_led", i), {31'd0, led0}, 32'd0);
        end
        chk("post_rst_led", {31'd0, led0}, 32'd1);
        chk("post_rst_rise", {31'd0, rise0}, 32'd1);
        chk("post_rst_cnt", {24'd0, cnt0}, 32'd1);
        chk("post_rst_inv_led", {31'd0, led1}, 32'd1);
        chk("post_rst_inv_cnt", {24'd0, cnt1}, 32'd1);
        tick();
        chk("post_rst_rise_end", {31'd0, rise0}, 32'd0);
        chk("post_rst_cnt_hold", {24'd0, cnt0}, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
